ebi_link_trx: RTL

EBI_LINK_TRX -- requirements
Module: ebi_link_trx

---
 rtl/ebi_link_pkg.sv | 20 ++
 rtl/ebi_link_chk.sv | 18 +
 rtl/ebi_link_trx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ebi_link_pkg.sv
// ebi_link_pkg: shared FSM states, opcodes, header layout and line patterns
package ebi_link_pkg;
  typedef enum logic [3:0] {
    IDLE, TX_START, TX_HDR, TX_PAY, TX_CHK, TX_STOP, TURN,
    RX_HDR, RX_PAY, RX_CHK, RX_STOP, RX_DRAIN
  } ebi_state_e;
  localparam logic [3:0] DR        = 4'h0;
  localparam logic [3:0] DW1       = 4'h1;
  localparam logic [3:0] DW2       = 4'h2;
  localparam logic [3:0] SNP_REQ   = 4'h3;
  localparam logic [3:0] SNP_RESP1 = 4'h4;
  localparam logic [3:0] SNP_RESP2 = 4'h5;
  localparam logic [3:0] RD_RESP   = 4'h6;
  localparam logic [3:0] ACK       = 4'h7;
  localparam int HDR_OPC_LSB = 0;
  localparam int HDR_LEN_W   = 6;
  localparam int PAT_W = 256;
  localparam logic [PAT_W-1:0] START_PAT = {{(PAT_W-1){1'b1}}, 1'b0};
  localparam logic [PAT_W-1:0] STOP_PAT  = {PAT_W{1'b1}};
endpackage

// File: rtl/ebi_link_chk.sv
// ebi_link_chk: running XOR checksum; clear with enable seeds it with d
module ebi_link_chk
  import ebi_link_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] acc
);
  // accumulate (or restart from d) whenever a beat is presented
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr || en) acc <= (clr ? '0 : acc) ^ (en ? d : '0);
endmodule

// File: rtl/ebi_link_trx.sv
// ebi_link_trx: half-duplex framed link over a shared pad bus
module ebi_link_trx
  import ebi_link_pkg::*;
#(
  parameter int EBI_WIDTH = 16,
  parameter int MAX_BEATS = 32,
  parameter int OPC_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [EBI_WIDTH-1:0]           ebi_o,
  input  logic [EBI_WIDTH-1:0]           ebi_i,
  output logic [EBI_WIDTH-1:0]           ebi_oen,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  input  logic [OPC_WIDTH-1:0]           tx_opcode,
  input  logic [5:0]                     tx_len,
  input  logic [MAX_BEATS*EBI_WIDTH-1:0] tx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic [OPC_WIDTH-1:0]           rx_opcode,
  output logic [5:0]                     rx_len,
  output logic [MAX_BEATS*EBI_WIDTH-1:0] rx_data,
  output logic                           rx_chk_err,
  output logic                           rx_frm_err,
  output logic                           rx_overrun,
  output logic                           busy
);
  localparam int W = EBI_WIDTH;
  localparam int DW = MAX_BEATS * EBI_WIDTH;
  localparam logic [5:0] MAXB = 6'(MAX_BEATS);
  localparam logic [W-1:0] ONES = STOP_PAT[W-1:0];
  localparam logic [W-1:0] START_W = START_PAT[W-1:0];
  ebi_state_e state;
  logic [W-1:0] rff, hdr_w, chk_d, acc;
  logic [OPC_WIDTH-1:0] t_opc, s_opc;
  logic [5:0] t_len, s_len, cnt, idx, rlen, tx_len_c;
  logic [DW-1:0] t_sh, shadow;
  logic chk_clr, chk_en, pend;
  assign rlen = rff[OPC_WIDTH +: HDR_LEN_W];
  assign tx_len_c = tx_len > MAXB ? MAXB : tx_len;
  assign tx_ready = !rst && state == IDLE && rff[0];
  assign busy = state != IDLE;
  assign chk_clr = state inside {TX_START, RX_HDR};
  assign chk_en = chk_clr || state == RX_PAY || (state inside {TX_HDR, TX_PAY} && cnt != '0);
  assign chk_d = state == TX_START ? hdr_w : state inside {RX_HDR, RX_PAY} ? rff : t_sh[W-1:0];
  // header word built from the latched transmit fields, unused bits zero
  always_comb begin
    hdr_w = '0;
    hdr_w[HDR_OPC_LSB +: OPC_WIDTH] = t_opc;
    hdr_w[OPC_WIDTH +: HDR_LEN_W] = t_len;
  end
  ebi_link_chk #(.W(W)) u_chk (
    .clk(clk), .rst(rst), .clr(chk_clr), .en(chk_en), .d(chk_d), .acc(acc)
  );
  // link FSM; pad outputs are loaded with the beat of the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rff <= '1;
      ebi_o <= '1;
      ebi_oen <= '1;
      t_opc <= '0;
      t_len <= '0;
      t_sh <= '0;
      cnt <= '0;
      idx <= '0;
      s_opc <= '0;
      s_len <= '0;
      shadow <= '0;
      pend <= 1'b0;
      rx_valid <= 1'b0;
      rx_opcode <= '0;
      rx_len <= '0;
      rx_data <= '0;
      rx_chk_err <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rff <= ebi_i;
      rx_chk_err <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (!rff[0]) state <= RX_HDR;
          else if (tx_valid) begin
            state <= TX_START;
            ebi_o <= START_W;
            ebi_oen <= '0;
            t_opc <= tx_opcode;
            t_len <= tx_len_c;
            cnt <= tx_len_c;
            t_sh <= tx_data;
          end
        TX_START: begin
          state <= TX_HDR;
          ebi_o <= hdr_w;
        end
        TX_HDR, TX_PAY:
          if (cnt == '0) begin
            state <= TX_CHK;
            ebi_o <= acc;
          end else begin
            state <= TX_PAY;
            ebi_o <= t_sh[W-1:0];
            t_sh <= t_sh >> W;
            cnt <= cnt - 6'd1;
          end
        TX_CHK: begin
          state <= TX_STOP;
          ebi_o <= ONES;
        end
        TX_STOP: begin
          state <= TURN;
          ebi_oen <= '1;
        end
        TURN: state <= IDLE;
        RX_HDR: begin
          s_opc <= rff[HDR_OPC_LSB +: OPC_WIDTH];
          s_len <= rlen;
          cnt <= rlen;
          idx <= '0;
          shadow <= '0;
          pend <= 1'b0;
          rx_frm_err <= rlen > MAXB;
          state <= rlen > MAXB ? RX_DRAIN : rlen == '0 ? RX_CHK : RX_PAY;
        end
        RX_PAY: begin
          shadow[int'(idx)*W +: W] <= rff;
          idx <= idx + 6'd1;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= RX_CHK;
        end
        RX_CHK: begin
          pend <= rff != acc;
          state <= RX_STOP;
        end
        RX_STOP: begin
          state <= IDLE;
          if (rff != ONES) rx_frm_err <= 1'b1;
          else if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
          else begin
            rx_valid <= 1'b1;
            rx_opcode <= s_opc;
            rx_len <= s_len;
            rx_data <= shadow;
            rx_chk_err <= pend;
          end
        end
        RX_DRAIN: if (rff == ONES) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
